ctrl_pipe_unit: RTL and testbench
=================================

// Module: ctrl_pipe_unit
// PURPOSE
//  Pipelined successor to the single-cycle opcode decoder. Decodes the WISC opcode in ID,
//  then carries the control bundles through EX/MEM/WB stage registers. Adds load-use and
//  RAW hazard stalls, memory-wait freeze, taken-branch flush and a HLT drain/halt FSM.
//  Sits between the IF/ID register and the datapath; the datapath consumes the per-stage bundles.
// PARAMETERS
//  REG_ADDR_W  4  register-index width; dest/source compare width
//  BR_FLUSH    1  cycles flush_ifid is held after a taken branch (1..7)
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           async active-low reset
//  id_valid       in   1           ID slot holds a real instruction
//  id_opcode      in   4           opcode of ID instruction
//  id_rs/id_rt/id_rd in REG_ADDR_W source A, source B, destination
//  br_taken       in   1           branch unit: ID branch resolved taken
//  mem_ready      in   1           data memory completes access this cycle
//  id_branch      out  1           comb: opcode 1100/1101
//  id_branch_reg  out  1           comb: opcode 1101
//  stall_pc       out  1           hold PC and IF/ID
//  flush_ifid     out  1           squash IF/ID contents
//  ex_valid/mem_valid/wb_valid out 1  stage holds real instruction
//  ex_ctrl        out  3           {RegDst,AluSrc,MemHalf}
//  mem_ctrl       out  3           {MemEnable,MemWrite,MemtoReg}
//  wb_ctrl        out  2           {RegWrite,PC}
//  wb_rd          out  REG_ADDR_W  WB destination
//  fwd_a/fwd_b    out  2           EX operand source: 00 regfile, 01 WB, 10 MEM
//  halted         out  1           core halted
// BEHAVIOUR
//  Decode: 0000-0011 RegDst,AluSrc,RegWrite; 0111 same; 0100-0110 RegDst,RegWrite;
//   1000 MemEnable,MemtoReg,RegWrite; 1001 MemEnable,MemWrite; 1010/1011 MemHalf,RegWrite;
//   1100 Branch; 1101 Branch,BranchReg; 1110 RegWrite,PC; 1111 HLT (no bits). Reads rt: 0000-0011,0111,1001.
//  Reset: all stage regs, outputs, flush counter cleared; FSM=RUN. Decode outputs are
//   combinational from id_opcode and are the only outputs not forced to 0.
//  Invalid slot / bubble: valid=0, all ctrl bits 0, rd=0. Register 0 never matches a hazard.
//  Priority each cycle: freeze > hazard bubble > flush > normal advance.
//  Freeze: mem_valid&MemEnable&!mem_ready -> EX,MEM hold; WB loads bubble; stall_pc=1.
//  Load-use: ex_valid&MemtoReg&ex_rd!=0&(ex_rd==id_rs | rt-user&ex_rd==id_rt) -> EX loads bubble,
//   stall_pc=1, MEM/WB advance; 1-cycle penalty.
//  Branch: id_valid&id_branch&br_taken, not stalled -> flush_ifid=1 for BR_FLUSH cycles (3-bit counter);
//   ID treated invalid while counter>0; new taken branch during count is impossible (ID squashed).
//  HLT FSM: RUN --HLT in ID, not stalled--> DRAIN: HLT enters EX as bubble, stall_pc=1 from next
//   cycle. DRAIN --ex/mem/wb_valid all 0--> HALTED: halted=1, stall_pc=1, sticky until rst_n.
//  Reset mid-operation: async clear wins over freeze/flush; no partial state survives.
// CONFIGURATION
//  CTRL_PIPE_FWD_EN defined: EX stores rs/rt; fwd_a/b = 10 if mem writes match (RegWrite, rd!=0),
//   else 01 if WB match, else 00; only load-use stalls.
//  Undefined: fwd_a/b tied 00; any ID source matching a valid RegWrite dest in EX, MEM or WB
//   inserts bubble (stall_pc=1) until the writer leaves WB.
// TESTING
//  ADD r1 ; ADD r2,r1,r3 (FWD_EN) -> no stall, fwd_a=10 in 2nd EX cycle; without FWD_EN 3 bubbles.
//  LW r4 ; ADD r5,r4,r6 -> stall_pc=1 exactly 1 cycle, ex_valid=0 that cycle, fwd_a=01 after.
//  LW with mem_ready=0 for 3 cycles -> stall_pc=1 3 cycles, mem_ctrl=3'b101 held, wb_valid=0 x3.
//  B taken, BR_FLUSH=2 -> flush_ifid=1 two consecutive cycles, ex_valid=0 for both squashed slots.
//  LW ; HLT -> DRAIN 3 cycles then halted=1; stall_pc stays 1; rst_n low mid-drain -> all 0, RUN.
//  SW r7 uses rt: ADD r7 ; SW r7 (no FWD_EN) -> stall; opcode 0101 with id_rt==ex_rd -> no stall.

Source files
------------

// File: rtl/ctrl_pipe_unit.sv
// Pipelined WISC control unit: ID decode plus EX/MEM/WB control bundles, hazard stalls,
// memory freeze, branch flush and HLT drain. Optional forwarding build: CTRL_PIPE_FWD_EN.
module ctrl_pipe_unit #(
   parameter int REG_ADDR_W = 4,
   parameter int BR_FLUSH   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [3:0]            id_opcode,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  br_taken,
   input  logic                  mem_ready,
   output logic                  id_branch,
   output logic                  id_branch_reg,
   output logic                  stall_pc,
   output logic                  flush_ifid,
   output logic                  ex_valid,
   output logic                  mem_valid,
   output logic                  wb_valid,
   output logic [2:0]            ex_ctrl,
   output logic [2:0]            mem_ctrl,
   output logic [1:0]            wb_ctrl,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  halted
);

   localparam int RW = REG_ADDR_W;

   localparam logic [1:0] ST_RUN    = 2'b00;
   localparam logic [1:0] ST_DRAIN  = 2'b01;
   localparam logic [1:0] ST_HALTED = 2'b10;

   typedef struct packed {
      logic          vld;
      logic [2:0]    ex;    // {RegDst,AluSrc,MemHalf}
      logic [2:0]    mem;   // {MemEnable,MemWrite,MemtoReg}
      logic [1:0]    wb;    // {RegWrite,PC}
      logic [RW-1:0] rd;
`ifdef CTRL_PIPE_FWD_EN
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
`endif
   } ex_stage_t;

   typedef struct packed {
      logic          vld;
      logic [2:0]    mem;
      logic [1:0]    wb;
      logic [RW-1:0] rd;
   } mem_stage_t;

   typedef struct packed {
      logic          vld;
      logic [1:0]    wb;
      logic [RW-1:0] rd;
   } wb_stage_t;

   ex_stage_t  ex_q,  ex_d;
   mem_stage_t mem_q, mem_d;
   wb_stage_t  wb_q,  wb_d;
   logic [2:0] flush_cnt;
   logic [1:0] state;

   logic [2:0] d_ex;
   logic [2:0] d_mem;
   logic [1:0] d_wb;
   logic       d_rt_use;
   logic       d_hlt;

   always_comb begin
      d_ex          = 3'b000;
      d_mem         = 3'b000;
      d_wb          = 2'b00;
      d_rt_use      = 1'b0;
      id_branch     = 1'b0;
      id_branch_reg = 1'b0;
      case (id_opcode)
         4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: begin
            d_ex     = 3'b110;
            d_wb     = 2'b10;
            d_rt_use = 1'b1;
         end
         4'b0100, 4'b0101, 4'b0110: begin
            d_ex = 3'b100;
            d_wb = 2'b10;
         end
         4'b1000: begin
            d_mem = 3'b101;
            d_wb  = 2'b10;
         end
         4'b1001: begin
            d_mem    = 3'b110;
            d_rt_use = 1'b1;
         end
         4'b1010, 4'b1011: begin
            d_ex = 3'b001;
            d_wb = 2'b10;
         end
         4'b1100: id_branch = 1'b1;
         4'b1101: begin
            id_branch     = 1'b1;
            id_branch_reg = 1'b1;
         end
         4'b1110: d_wb = 2'b11;
         default: ;
      endcase
   end

   assign d_hlt = (id_opcode == 4'b1111);

   // True when a writing stage's destination feeds one of the ID sources; r0 never matches.
   function automatic logic src_hit(input logic v, input logic w, input logic [RW-1:0] rd,
                                    input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                    input logic rt_use);
      return v && w && (rd != '0) && ((rd == rs) || (rt_use && (rd == rt)));
   endfunction

   logic id_live;
   logic freeze;
   logic hazard;
   logic accept;
   logic take_br;
   logic go_hlt;

   assign id_live = id_valid && (flush_cnt == 3'd0) && (state == ST_RUN);
   assign freeze  = mem_q.vld && mem_q.mem[2] && !mem_ready;

`ifdef CTRL_PIPE_FWD_EN
   assign hazard = id_live &&
                   src_hit(ex_q.vld, ex_q.mem[0], ex_q.rd, id_rs, id_rt, d_rt_use);
`else
   assign hazard = id_live &&
                   (src_hit(ex_q.vld,  ex_q.wb[1],  ex_q.rd,  id_rs, id_rt, d_rt_use) ||
                    src_hit(mem_q.vld, mem_q.wb[1], mem_q.rd, id_rs, id_rt, d_rt_use) ||
                    src_hit(wb_q.vld,  wb_q.wb[1],  wb_q.rd,  id_rs, id_rt, d_rt_use));
`endif

   assign accept   = id_live && !freeze && !hazard;
   assign take_br  = accept && id_branch && br_taken;
   assign go_hlt   = accept && d_hlt;
   assign stall_pc = freeze || hazard || (state != ST_RUN);

   always_comb begin
      ex_d = '0;
      if (freeze) begin
         ex_d = ex_q;
      end else if (accept && !d_hlt) begin
         ex_d.vld = 1'b1;
         ex_d.ex  = d_ex;
         ex_d.mem = d_mem;
         ex_d.wb  = d_wb;
         ex_d.rd  = id_rd;
`ifdef CTRL_PIPE_FWD_EN
         ex_d.rs  = id_rs;
         ex_d.rt  = d_rt_use ? id_rt : '0;
`endif
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (!freeze) begin
         mem_d.vld = ex_q.vld;
         mem_d.mem = ex_q.mem;
         mem_d.wb  = ex_q.wb;
         mem_d.rd  = ex_q.rd;
      end
   end

   // A frozen MEM access must not retire twice, so WB takes a bubble while frozen.
   always_comb begin
      wb_d = '0;
      if (!freeze) begin
         wb_d.vld = mem_q.vld;
         wb_d.wb  = mem_q.wb;
         wb_d.rd  = mem_q.rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         flush_cnt <= 3'd0;
         state     <= ST_RUN;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         if (take_br)
            flush_cnt <= 3'(BR_FLUSH);
         else if (flush_cnt != 3'd0)
            flush_cnt <= flush_cnt - 3'd1;
         case (state)
            ST_RUN:   if (go_hlt) state <= ST_DRAIN;
            ST_DRAIN: if (!ex_q.vld && !mem_q.vld && !wb_q.vld) state <= ST_HALTED;
            default:  state <= state;
         endcase
      end
   end

`ifdef CTRL_PIPE_FWD_EN
   logic mem_wr;
   logic wb_wr;
   assign mem_wr = mem_q.vld && mem_q.wb[1] && (mem_q.rd != '0);
   assign wb_wr  = wb_q.vld  && wb_q.wb[1]  && (wb_q.rd  != '0);
   assign fwd_a  = (mem_wr && (mem_q.rd == ex_q.rs)) ? 2'b10 :
                   (wb_wr  && (wb_q.rd  == ex_q.rs)) ? 2'b01 : 2'b00;
   assign fwd_b  = (mem_wr && (mem_q.rd == ex_q.rt)) ? 2'b10 :
                   (wb_wr  && (wb_q.rd  == ex_q.rt)) ? 2'b01 : 2'b00;
`else
   assign fwd_a = 2'b00;
   assign fwd_b = 2'b00;
`endif

   assign flush_ifid = (flush_cnt != 3'd0);
   assign ex_valid   = ex_q.vld;
   assign ex_ctrl    = ex_q.ex;
   assign mem_valid  = mem_q.vld;
   assign mem_ctrl   = mem_q.mem;
   assign wb_valid   = wb_q.vld;
   assign wb_ctrl    = wb_q.wb;
   assign wb_rd      = wb_q.rd;
   assign halted     = (state == ST_HALTED);

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: decode sweep through a stage scoreboard plus directed hazard,
// freeze, flush and halt scenarios.
module tb_ctrl_pipe_unit;
   localparam int RW = 4;
`ifdef CTRL_PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          id_valid = 1'b0;
   logic [3:0]    id_opcode = 4'd0;
   logic [RW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
   logic          br_taken = 1'b0;
   logic          mem_ready = 1'b1;
   logic          id_branch, id_branch_reg, stall_pc, flush_ifid;
   logic          ex_valid, mem_valid, wb_valid, halted;
   logic [2:0]    ex_ctrl, mem_ctrl;
   logic [1:0]    wb_ctrl, fwd_a, fwd_b;
   logic [RW-1:0] wb_rd;

   always #5 clk = ~clk;

   ctrl_pipe_unit #(.REG_ADDR_W(RW), .BR_FLUSH(2)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .br_taken(br_taken),
      .mem_ready(mem_ready), .id_branch(id_branch), .id_branch_reg(id_branch_reg),
      .stall_pc(stall_pc), .flush_ifid(flush_ifid), .ex_valid(ex_valid),
      .mem_valid(mem_valid), .wb_valid(wb_valid), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
      .wb_ctrl(wb_ctrl), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // {RegDst,AluSrc,MemHalf, MemEnable,MemWrite,MemtoReg, RegWrite,PC}
   function automatic logic [7:0] exp_ctrl(input logic [3:0] op);
      case (op)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd7: return 8'b110_000_10;
         4'd4, 4'd5, 4'd6:             return 8'b100_000_10;
         4'd8:                         return 8'b000_101_10;
         4'd9:                         return 8'b000_110_00;
         4'd10, 4'd11:                 return 8'b001_000_10;
         4'd14:                        return 8'b000_000_11;
         default:                      return 8'b000_000_00;
      endcase
   endfunction

   logic [2:0]      q_ex[$];
   logic [2:0]      q_mem[$];
   logic [RW+1:0]   q_wb[$];
   bit              sb_on = 1'b0;

   always @(negedge clk) begin
      if (sb_on && rst_n) begin
         if (ex_valid) begin
            if (q_ex.size() == 0) chk("sb_ex_underflow", 32'(q_ex.size()), 32'd1);
            else chk("sb_ex_ctrl", 32'(ex_ctrl), 32'(q_ex.pop_front()));
         end
         if (mem_valid) begin
            if (q_mem.size() == 0) chk("sb_mem_underflow", 32'(q_mem.size()), 32'd1);
            else chk("sb_mem_ctrl", 32'(mem_ctrl), 32'(q_mem.pop_front()));
         end
         if (wb_valid) begin
            if (q_wb.size() == 0) chk("sb_wb_underflow", 32'(q_wb.size()), 32'd1);
            else chk("sb_wb_ctrl_rd", 32'({wb_ctrl, wb_rd}), 32'(q_wb.pop_front()));
         end
      end
   end

   task automatic drv(input logic v, input logic [3:0] op, input logic [RW-1:0] rs,
                      input logic [RW-1:0] rt, input logic [RW-1:0] rd);
      id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
   endtask

   task automatic adv();
      @(posedge clk); #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_stall"}, 32'(stall_pc), 32'd0);
      chk({tag, "_flush"}, 32'(flush_ifid), 32'd0);
      chk({tag, "_valids"}, 32'({ex_valid, mem_valid, wb_valid}), 32'd0);
      chk({tag, "_ctrl"}, 32'({ex_ctrl, mem_ctrl, wb_ctrl, wb_rd}), 32'd0);
      chk({tag, "_fwd_halt"}, 32'({fwd_a, fwd_b, halted}), 32'd0);
   endtask

   task automatic do_reset();
      drv(1'b0, 4'd0, '0, '0, '0);
      br_taken = 1'b0; mem_ready = 1'b1;
      rst_n = 1'b0;
      smp();
      chk_zero("rst");
      rst_n = 1'b1;
      adv();
   endtask

   task automatic count_stall(output int n);
      n = 0;
      smp();
      while (stall_pc && n < 20) begin
         n++; adv(); smp();
      end
   endtask

   int n;
   logic [7:0] e;

   initial begin
      #2;
      // decode sweep through the scoreboard
      do_reset();
      sb_on = 1'b1;
      for (int op = 0; op < 16; op++) begin
         drv(op < 15, 4'(op), '0, '0, 4'(op + 1));
         if (op < 15) begin
            e = exp_ctrl(4'(op));
            q_ex.push_back(e[7:5]);
            q_mem.push_back(e[4:2]);
            q_wb.push_back({e[1:0], 4'(op + 1)});
         end
         smp();
         chk("id_branch", 32'(id_branch), 32'(op == 12 || op == 13));
         chk("id_branch_reg", 32'(id_branch_reg), 32'(op == 13));
         chk("sweep_stall", 32'(stall_pc), 32'd0);
         adv();
      end
      drv(1'b0, 4'd0, '0, '0, '0);
      repeat (4) adv();
      chk("sb_left", 32'(q_ex.size() + q_mem.size() + q_wb.size()), 32'd0);
      sb_on = 1'b0;

      // ADD r1 ; ADD r2,r1,r3
      do_reset();
      drv(1'b1, 4'd0, 4'd5, 4'd6, 4'd1); smp();
      chk("raw_c0_stall", 32'(stall_pc), 32'd0); adv();
      drv(1'b1, 4'd0, 4'd1, 4'd3, 4'd2);
      count_stall(n);
      chk("raw_stall_cycles", 32'(n), FWD ? 32'd0 : 32'd3);
      chk("raw_ex_at_release", 32'(ex_valid), FWD ? 32'd1 : 32'd0);
      adv(); drv(1'b0, 4'd0, '0, '0, '0); smp();
      chk("raw_ex_valid", 32'(ex_valid), 32'd1);
      chk("raw_ex_ctrl", 32'(ex_ctrl), 32'b110);
      chk("raw_fwd_a", 32'(fwd_a), FWD ? 32'd2 : 32'd0);
      chk("raw_fwd_b", 32'(fwd_b), 32'd0);

      // LW r4 ; ADD r5,r4,r6
      do_reset();
      drv(1'b1, 4'b1000, 4'd0, 4'd0, 4'd4); adv();
      drv(1'b1, 4'd0, 4'd4, 4'd6, 4'd5);
      count_stall(n);
      chk("lu_stall_cycles", 32'(n), FWD ? 32'd1 : 32'd3);
      chk("lu_ex_bubble", 32'(ex_valid), 32'd0);
      adv(); drv(1'b0, 4'd0, '0, '0, '0); smp();
      chk("lu_ex_valid", 32'(ex_valid), 32'd1);
      chk("lu_fwd_a", 32'(fwd_a), FWD ? 32'd1 : 32'd0);

      // ADD r7 ; SW rt=r7, then non-rt user 0101
      do_reset();
      drv(1'b1, 4'd0, 4'd0, 4'd0, 4'd7); adv();
      drv(1'b1, 4'b1001, 4'd0, 4'd7, 4'd0);
      count_stall(n);
      chk("sw_rt_stall", 32'(n), FWD ? 32'd0 : 32'd3);
      do_reset();
      drv(1'b1, 4'd0, 4'd0, 4'd0, 4'd7); adv();
      drv(1'b1, 4'b0101, 4'd0, 4'd7, 4'd8);
      count_stall(n);
      chk("nort_stall", 32'(n), 32'd0);

      // LW ; ADD then memory wait 3 cycles
      do_reset();
      drv(1'b1, 4'b1000, 4'd0, 4'd0, 4'd4); adv();
      drv(1'b1, 4'd0, 4'd0, 4'd0, 4'd9); adv();
      drv(1'b0, 4'd0, '0, '0, '0); mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("frz_stall", 32'(stall_pc), 32'd1);
         chk("frz_mem", 32'({mem_valid, mem_ctrl}), 32'b1101);
         chk("frz_wb_valid", 32'(wb_valid), 32'd0);
         chk("frz_ex_hold", 32'({ex_valid, ex_ctrl}), 32'b1110);
         adv();
      end
      mem_ready = 1'b1; smp();
      chk("frz_release", 32'(stall_pc), 32'd0);
      adv(); smp();
      chk("frz_wb", 32'({wb_valid, wb_ctrl, wb_rd}), 32'({1'b1, 2'b10, 4'd4}));
      chk("frz_mem_next", 32'({mem_valid, mem_ctrl}), 32'b1000);
      chk("frz_ex_empty", 32'(ex_valid), 32'd0);

      // taken branch with a two-cycle flush
      do_reset();
      drv(1'b1, 4'b1100, 4'd0, 4'd0, 4'd0); br_taken = 1'b1; smp();
      chk("br_c0_flush", 32'(flush_ifid), 32'd0);
      chk("br_c0_stall", 32'(stall_pc), 32'd0);
      adv();
      br_taken = 1'b0; drv(1'b1, 4'd0, 4'd0, 4'd0, 4'd3); smp();
      chk("br_c1", 32'({flush_ifid, ex_valid}), 32'b11); adv(); smp();
      chk("br_c2", 32'({flush_ifid, ex_valid}), 32'b10); adv(); smp();
      chk("br_c3", 32'({flush_ifid, ex_valid}), 32'b00); adv(); smp();
      chk("br_c4", 32'({ex_valid, ex_ctrl}), 32'b1110);

      // LW ; HLT drain to halt
      do_reset();
      drv(1'b1, 4'b1000, 4'd0, 4'd0, 4'd4); adv();
      drv(1'b1, 4'b1111, 4'd0, 4'd0, 4'd0); smp();
      chk("hlt_id_stall", 32'(stall_pc), 32'd0); adv();
      drv(1'b1, 4'd0, 4'd0, 4'd0, 4'd5);
      n = 0; smp();
      while (!halted && n < 20) begin
         chk("drain_stall", 32'(stall_pc), 32'd1);
         n++; adv(); smp();
      end
      chk("drain_cycles", 32'(n), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk("halt_state", 32'({halted, stall_pc, ex_valid}), 32'b110);
         adv(); smp();
      end

      // reset asserted mid-drain
      do_reset();
      drv(1'b1, 4'b1000, 4'd0, 4'd0, 4'd4); adv();
      drv(1'b1, 4'b1111, 4'd0, 4'd0, 4'd0); adv();
      drv(1'b0, 4'd0, '0, '0, '0); smp();
      chk("mid_drain_stall", 32'(stall_pc), 32'd1);
      #1 rst_n = 1'b0; #1;
      chk_zero("mid_rst");
      smp(); rst_n = 1'b1; adv();
      drv(1'b1, 4'd0, 4'd0, 4'd0, 4'd6); smp();
      chk("post_rst_stall", 32'(stall_pc), 32'd0); adv();
      drv(1'b0, 4'd0, '0, '0, '0); smp();
      chk("post_rst_run", 32'({ex_valid, halted}), 32'b10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got running want finished");
      $fatal(1);
   end
endmodule
